// File: rtl/multicycle_controlunit.sv
// rtl/multicycle_controlunit.sv - multi-cycle RV32I main controller (optional trap: MCU_ILLEGAL_TRAP_EN)
module multicycle_controlunit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       memreq,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       pcupdate,
    output logic       branch,
    output logic       regwrite,
    output logic       memwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] immsrc,
    output logic       illegal,
    output logic       memerr
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_HALT
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // Counter is at least one bit wide so a disabled timeout still elaborates.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(MEM_TIMEOUT);

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          mem_state;
    logic          timeout_hit;
    logic          memreq_s, irwrite_s, pcupdate_s, branch_s, regwrite_s, memwrite_s;

    assign mem_state   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (wait_cnt == TMAX);

    // Strobes are forced low while reset is held, independent of the clock.
    assign memreq   = rst_n & memreq_s;
    assign irwrite  = rst_n & irwrite_s;
    assign pcupdate = rst_n & pcupdate_s;
    assign branch   = rst_n & branch_s;
    assign regwrite = rst_n & regwrite_s;
    assign memwrite = rst_n & memwrite_s;

    // Immediate format follows the instruction register in every state.
    always_comb begin
        immsrc = 2'b00;
        case (opcode)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_nxt  = state;
        memreq_s   = 1'b0;
        adrsrc     = 1'b0;
        irwrite_s  = 1'b0;
        pcupdate_s = 1'b0;
        branch_s   = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        case (state)
            S_FETCH: begin
                memreq_s  = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (mem_ready) begin
                    irwrite_s  = 1'b1;
                    pcupdate_s = 1'b1;
                    state_nxt  = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_JAL:       state_nxt = S_JAL;
                    OP_BEQ:       state_nxt = S_BEQ;
`ifdef MCU_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_HALT;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alusrca   = 2'b10;
                alusrcb   = 2'b01;
                state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memreq_s = 1'b1;
                adrsrc   = 1'b1;
                if (mem_ready)        state_nxt = S_MEMWB;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_s = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                memreq_s   = 1'b1;
                memwrite_s = 1'b1;
                adrsrc     = 1'b1;
                if (mem_ready)        state_nxt = S_FETCH;
                else if (timeout_hit) state_nxt = S_HALT;
            end
            S_EXECR: begin
                alusrca   = 2'b10;
                aluop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alusrca   = 2'b10;
                alusrcb   = 2'b01;
                aluop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JAL: begin
                alusrca    = 2'b01;
                alusrcb    = 2'b10;
                pcupdate_s = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca   = 2'b10;
                aluop     = 2'b01;
                branch_s  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // State register, memory wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            memerr   <= 1'b0;
        end else begin
            state  <= state_nxt;
            memerr <= memerr | timeout_hit;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready && wait_cnt != TMAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

`ifdef MCU_ILLEGAL_TRAP_EN
    logic bad_op;
    assign bad_op = (state == S_DECODE) &&
                    !((opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                      (opcode == OP_I) || (opcode == OP_JAL) || (opcode == OP_BEQ));

    // Sticky flag for an unsupported opcode seen in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal <= 1'b0;
        else        illegal <= illegal | bad_op;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_controlunit.md
# multicycle_controlunit

Main controller for the multi-cycle RV32I core, the next generation of the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving one shared ALU and one unified memory port. The memory port uses a `memreq`/`mem_ready` handshake with a bounded wait. The block supports R-type, addi-class I-type, lw, sw, beq and jal.

## Interface

- `MEM_TIMEOUT`, default 16: maximum cycles to wait for `mem_ready` in any memory state. 0 disables the timeout. Counter width is `$clog2(MEM_TIMEOUT+1)`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `opcode` in 7: `instr[6:0]` from the instruction register; sampled in DECODE.
- `mem_ready` in 1: memory completion for the current request.
- `memreq` out 1: memory access request.
- `adrsrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `irwrite` out 1: load the instruction register.
- `pcupdate` out 1: write the PC unconditionally.
- `branch` out 1: PC write when ALU zero is set.
- `regwrite` out 1: register file write enable.
- `memwrite` out 1: memory write enable.
- `resultsrc` out 2: result select; 00 ALUOut, 01 Data, 10 ALUResult.
- `alusrca` out 2: ALU A select; 00 PC, 01 OldPC, 10 rs1.
- `alusrcb` out 2: ALU B select; 00 rs2, 01 ImmExt, 10 constant 4.
- `aluop` out 2: ALU op class; 00 add, 01 sub, 10 funct-decoded.
- `immsrc` out 2: immediate format; 00 I, 01 S, 10 B, 11 J.
- `illegal` out 1: sticky unsupported-opcode flag.
- `memerr` out 1: sticky memory-timeout flag.

## Operation

- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ, HALT.
- Any output not listed for a state is 0.
- **FETCH**:
  - Outputs: `memreq`=1, `adrsrc`=0, `alusrca`=00, `alusrcb`=10, `aluop`=00, `resultsrc`=10.
  - `irwrite` and `pcupdate` are asserted only in the cycle where `mem_ready`=1; the state then advances to DECODE.
- **DECODE**:
  - Outputs: `alusrca`=01, `alusrcb`=01, `aluop`=00.
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - other opcodes → see Configuration
- **MEMADR**:
  - Outputs: `alusrca`=10, `alusrcb`=01, `aluop`=00.
  - Next state: lw → MEMREAD; sw → MEMWRITE.
- **MEMREAD**:
  - Outputs: `memreq`=1, `adrsrc`=1, `resultsrc`=00.
  - Holds until `mem_ready`, then → MEMWB.
- **MEMWB**: `resultsrc`=01, `regwrite`=1; → FETCH.
- **MEMWRITE**:
  - Outputs: `memreq`=1, `memwrite`=1, `adrsrc`=1, `resultsrc`=00.
  - `memwrite` stays high for the whole stall; → FETCH on `mem_ready`.
- **EXECR**: `alusrca`=10, `alusrcb`=00, `aluop`=10; → ALUWB.
- **EXECI**: `alusrca`=10, `alusrcb`=01, `aluop`=10; → ALUWB.
- **ALUWB**: `resultsrc`=00, `regwrite`=1; → FETCH.
- **JAL**: `alusrca`=01, `alusrcb`=10, `aluop`=00, `resultsrc`=00, `pcupdate`=1; → ALUWB.
- **BEQ**: `alusrca`=10, `alusrcb`=00, `aluop`=01, `resultsrc`=00, `branch`=1; → FETCH.
- **immsrc** is combinational from `opcode` in every state:
  - lw/addi → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - else → 00
- **Timeout counter**:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each stalled cycle.
  - When it reaches `MEM_TIMEOUT` with `mem_ready` still 0, `memerr` is set and the state goes to HALT.
- **HALT**: all strobes 0; terminal until reset.
- **Memory states**: `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.

## Timing

- **Reset**: `rst_n` low forces the state to FETCH and clears the counter, `illegal` and `memerr`. While low, all strobes are 0: `memreq`, `irwrite`, `pcupdate`, `regwrite`, `memwrite`, `branch`.
- **Reset mid-operation**: a reset during MEMWRITE drops `memwrite` immediately, without waiting for a clock edge.
- **Latency** with zero wait states (`mem_ready` high in the first cycle):
  - lw: 5 cycles
  - sw, R-type, addi, jal: 4 cycles
  - beq: 3 cycles
- Each wait cycle adds 1 to these counts.
- **Moore outputs**: all outputs are functions of the state, except `irwrite`/`pcupdate` (gated by `mem_ready`) and `immsrc` (from `opcode`).
- **Timeout boundary**:
  - `mem_ready` arriving in the same cycle the counter reaches `MEM_TIMEOUT` counts as success, not timeout.
  - `memerr` rises on the following edge.

## Configuration

- **Macro**: `MCU_ILLEGAL_TRAP_EN`.
- **Defined**: an unsupported opcode in DECODE sets `illegal` and goes to HALT.
- **Undefined**: an unsupported opcode in DECODE returns to FETCH (executes as a nop) and `illegal` is tied 0.

## Test plan

- **R-type add**: opcode 0110011, `mem_ready` always 1 → FETCH, DECODE, EXECR, ALUWB. `aluop`=10 in EXECR; `regwrite`=1 only in cycle 4; next FETCH in cycle 5.
- **lw with 3 wait cycles in MEMREAD**: `memreq`=1 and `adrsrc`=1 for 4 cycles; `regwrite` pulses once with `resultsrc`=01; total 8 cycles.
- **sw with 2 wait cycles**: `memwrite` high for exactly 3 consecutive cycles; `regwrite` never 1.
- **beq then jal**:
  - beq: `branch`=1 in cycle 3 with `aluop`=01, `immsrc`=10.
  - jal: `pcupdate`=1 in the JAL state and `immsrc`=11.
- **Timeout**: `MEM_TIMEOUT`=4 and `mem_ready` held 0 in FETCH → `memerr`=1 after the 5th stall cycle. The state stays in HALT with all strobes 0 until `rst_n` pulses low, which clears `memerr`.
- **Unsupported opcode 0001111**:
  - Macro defined: `illegal`=1 and HALT.
  - Macro undefined: returns to FETCH in cycle 3 and `illegal`=0.
